// File: rtl/gen_sweep_pkg.sv
// Shared types and constants for the DDS frequency-sweep scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gen_sweep_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DWELL,
    STEP,
    DONE
  } state_t;

  localparam logic [2:0] ADDR_START = 3'd0;
  localparam logic [2:0] ADDR_STOP  = 3'd1;
  localparam logic [2:0] ADDR_STEP  = 3'd2;
  localparam logic [2:0] ADDR_DWELL = 3'd3;
  localparam logic [2:0] ADDR_MODE  = 3'd4;

  localparam int CONT_BIT = 0;
  localparam int TRI_BIT  = 1;

endpackage

// File: rtl/gen_sweep_ctrl_next.sv
// Next phase increment: clamped step, endpoint turn-around and end-of-sweep decision.
// Latency: purely combinational.
// Backpressure: none.
module sweep_next
  import gen_sweep_pkg::*;
#(
  parameter int W_PHASE = 8
) (
  input  logic [W_PHASE-1:0] cur,
  input  logic [W_PHASE-1:0] step,
  input  logic [W_PHASE-1:0] lo,
  input  logic [W_PHASE-1:0] hi,
  input  logic               dir,      // 1 = sweeping up
  input  logic [1:0]         mode,
  output logic [W_PHASE-1:0] nxt,
  output logic               nxt_dir,
  output logic               fin
);

  // One extra bit so cur+step / cur-step can be clamped instead of wrapping.
  logic [W_PHASE:0]   up_sum;
  logic [W_PHASE:0]   dn_diff;
  logic [W_PHASE-1:0] up_clamp;
  logic [W_PHASE-1:0] dn_clamp;
  logic               at_end;

  assign up_sum   = {1'b0, cur} + {1'b0, step};
  assign dn_diff  = {1'b0, cur} - {1'b0, step};
  assign up_clamp = (up_sum > {1'b0, hi}) ? hi : up_sum[W_PHASE-1:0];
  assign dn_clamp = (dn_diff[W_PHASE] || (dn_diff[W_PHASE-1:0] < lo)) ? lo : dn_diff[W_PHASE-1:0];
  assign at_end   = dir ? (cur >= hi) : (cur <= lo);

  // Choose the next value: advance, finish, restart from START, or reflect.
  always_comb begin
    nxt     = cur;
    nxt_dir = dir;
    fin     = 1'b0;
    if (step == '0) begin
      fin = 1'b1;
    end else if (!at_end) begin
      nxt = dir ? up_clamp : dn_clamp;
    end else if (!mode[CONT_BIT]) begin
      fin = 1'b1;
    end else if (!mode[TRI_BIT]) begin
      // Direction never changes in sawtooth mode, so START is lo when up, hi when down.
      nxt = dir ? lo : hi;
    end else if (lo == hi) begin
      nxt = cur;
    end else begin
      nxt_dir = ~dir;
      nxt     = dir ? dn_clamp : up_clamp;
    end
  end

endmodule

// File: rtl/gen_sweep_ctrl.sv
// Frequency-sweep scheduler driving phase-increment writes into the DDS generator.
// Latency: first write one cycle after start, then one write every max(DWELL,1)+1 cycles.
// Backpressure: none; gen accepts every write, abort/clr stop the sweep at the next edge.
module gen_sweep_ctrl
  import gen_sweep_pkg::*;
#(
  parameter int W_PHASE = 8,
  parameter int W_DWELL = 16
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               cfg_wr,
  input  logic [2:0]         cfg_addr,
  input  logic [31:0]        cfg_data,
  input  logic               start,
  input  logic               abort,
  output logic [31:0]        wr_data,
  output logic               wr_n,
  output logic [W_PHASE-1:0] cur_inc,
  output logic               busy,
  output logic               done
);

  state_t state, state_nxt;

  // Host-visible profile registers.
  logic [W_PHASE-1:0] cfg_start, cfg_stop, cfg_step;
  logic [W_DWELL-1:0] cfg_dwell;
  logic [1:0]         cfg_mode;

  // Profile snapshot taken on the start cycle; the running sweep only looks at these.
  logic [W_PHASE-1:0] snap_lo, snap_hi, snap_step;
  logic [W_DWELL-1:0] snap_deff;
  logic [1:0]         snap_mode;

  logic [W_PHASE-1:0] cur;
  logic               dir;
  logic [W_DWELL-1:0] cnt;

  logic [W_PHASE-1:0] nxt;
  logic               nxt_dir;
  logic               fin;

  logic do_load, do_write, do_reload;

  logic unused_cfg_hi;
  assign unused_cfg_hi = ^cfg_data[31:W_DWELL];

  assign cur_inc = cur;

  sweep_next #(.W_PHASE(W_PHASE)) u_next (
    .cur     (cur),
    .step    (snap_step),
    .lo      (snap_lo),
    .hi      (snap_hi),
    .dir     (dir),
    .mode    (snap_mode),
    .nxt     (nxt),
    .nxt_dir (nxt_dir),
    .fin     (fin)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and datapath controls; a sweep that is finished skips STEP and goes straight to DONE.
  always_comb begin
    state_nxt = state;
    do_load   = 1'b0;
    do_write  = 1'b0;
    do_reload = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
          do_load   = 1'b1;
        end
      end
      LOAD: begin
        busy      = 1'b1;
        do_reload = 1'b1;
        state_nxt = DWELL;
      end
      DWELL: begin
        busy = 1'b1;
        if (cnt == '0) begin
          if (fin) begin
            state_nxt = DONE;
          end else begin
            state_nxt = STEP;
            do_write  = 1'b1;
          end
        end
      end
      STEP: begin
        busy      = 1'b1;
        do_reload = 1'b1;
        state_nxt = DWELL;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
      do_load   = 1'b0;
      do_write  = 1'b0;
      do_reload = 1'b0;
    end
  end

  // Config registers, snapshot, registered gen write port and dwell counter.
  always_ff @(posedge clk) begin
    if (clr) begin
      cfg_start <= '0;
      cfg_stop  <= '0;
      cfg_step  <= W_PHASE'(1);
      cfg_dwell <= W_DWELL'(1);
      cfg_mode  <= 2'b00;
      snap_lo   <= '0;
      snap_hi   <= '0;
      snap_step <= W_PHASE'(1);
      snap_deff <= W_DWELL'(1);
      snap_mode <= 2'b00;
      cur       <= '0;
      dir       <= 1'b1;
      cnt       <= '0;
      wr_data   <= '0;
      wr_n      <= 1'b1;
    end else begin
      if (cfg_wr) begin
        case (cfg_addr)
          ADDR_START: cfg_start <= cfg_data[W_PHASE-1:0];
          ADDR_STOP:  cfg_stop  <= cfg_data[W_PHASE-1:0];
          ADDR_STEP:  cfg_step  <= cfg_data[W_PHASE-1:0];
          ADDR_DWELL: cfg_dwell <= cfg_data[W_DWELL-1:0];
          ADDR_MODE:  cfg_mode  <= cfg_data[1:0];
          default: ;
        endcase
      end

      wr_n <= ~(do_load | do_write);

      if (do_load) begin
        snap_lo   <= (cfg_start <= cfg_stop) ? cfg_start : cfg_stop;
        snap_hi   <= (cfg_start <= cfg_stop) ? cfg_stop : cfg_start;
        snap_step <= cfg_step;
        snap_deff <= (cfg_dwell == '0) ? W_DWELL'(1) : cfg_dwell;
        snap_mode <= cfg_mode;
        cur       <= cfg_start;
        dir       <= (cfg_start <= cfg_stop);
        wr_data   <= {{(32-W_PHASE){1'b0}}, cfg_start};
      end else if (do_write) begin
        cur       <= nxt;
        dir       <= nxt_dir;
        wr_data   <= {{(32-W_PHASE){1'b0}}, nxt};
      end

      if (do_reload)                          cnt <= snap_deff - W_DWELL'(1);
      else if (state == DWELL && cnt != '0)   cnt <= cnt - W_DWELL'(1);
    end
  end

endmodule

// File: doc/gen_sweep_ctrl.md
Name: gen_sweep_ctrl

Overview:
Frequency-sweep scheduler that sequences phase-increment writes into the DDS generator (`gen`). It holds a host-programmed sweep profile: start, stop, step, dwell time and mode. On start it steps the phase increment from start to stop, issuing one `gen` write per dwell interval. It drives `gen`'s `wr_data` / `wr_n` directly and sits between the host register interface and `gen`.

Parameters:
- W_PHASE, 8, width of the phase increment; must match `gen.W_PHASE`.
- W_DWELL, 16, width of the dwell counter in clk cycles.

Ports:
- clk  in  1  system clock
- clr  in  1  synchronous reset, active-high
- cfg_wr  in  1  config register write strobe
- cfg_addr  in  3  config register select
- cfg_data  in  32  config write data
- start  in  1  begin sweep (single-cycle pulse)
- abort  in  1  stop sweep immediately
- wr_data  out  32  to `gen.wr_data`; phase increment zero-extended
- wr_n  out  1  to `gen.wr_n`; active-low write strobe
- cur_inc  out  W_PHASE  increment currently programmed into `gen`
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep completion

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset clr is synchronous and active-high; every register updates on posedge clk only.
  - Reset values: wr_n=1, wr_data=0, cur_inc=0, busy=0, done=0, state=IDLE.
  - Config registers reset to: START=0, STOP=0, STEP=1, DWELL=1, MODE=0.
- Config map (cfg_data LSBs; upper bits ignored):
  - 0 START (W_PHASE bits)
  - 1 STOP (W_PHASE bits)
  - 2 STEP (W_PHASE bits)
  - 3 DWELL (W_DWELL bits)
  - 4 MODE: bit0 CONT (repeat), bit1 TRI (triangle)
  - Other addresses are ignored.
- Config writes:
  - cfg_wr is accepted in any state, including mid-sweep.
  - The sweep uses a snapshot of all five registers captured on the start cycle, so mid-sweep writes affect only the next sweep.
- Derived values:
  - lo = min(START, STOP), hi = max(START, STOP).
  - Initial direction is up if START <= STOP, otherwise down.
  - Effective dwell Deff = max(DWELL, 1).
- FSM states: IDLE, LOAD, DWELL, STEP, DONE.
  - IDLE: wr_n=1. start=1 captures the snapshot and moves to LOAD.
  - LOAD: one cycle. cur=START, wr_data={0,cur}, wr_n=0, busy=1. Loads dwell counter with Deff-1, then moves to DWELL.
  - DWELL: wr_n=1. Counter decrements each cycle; at 0, moves to STEP.
  - STEP: one cycle, computes next:
    - If STEP==0, go to DONE.
    - If cur is not at the direction endpoint (hi when up, lo when down): next = cur ± STEP, clamped to the endpoint. Compute in W_PHASE+1 bits so there is no wrap-around.
    - At the endpoint with CONT=0: go to DONE.
    - At the endpoint with CONT=1 and TRI=0: next=START, direction reset.
    - At the endpoint with CONT=1 and TRI=1: direction flips, then next = cur ∓ STEP, clamped to the opposite endpoint.
    - If lo==hi in triangle mode, next=cur.
    - Otherwise: cur=next, wr_data={0,next}, wr_n=0 this cycle, reload counter with Deff-1, go to DWELL.
  - DONE: done=1 for one cycle, busy=0, go to IDLE. cur_inc holds its last value.
- Timing:
  - start sampled at cycle T gives the first write at T+1.
  - Subsequent writes occur every Deff+1 cycles (DWELL state plus the STEP cycle).
  - wr_n is low for exactly one cycle per write.
  - cur_inc updates in the same cycle as wr_n=0.
- Boundary and priority rules:
  - abort has priority over start and over any state. The next state is IDLE, wr_n=1 that cycle, busy=0, done is not asserted, cur_inc unchanged.
  - start while busy is ignored.
  - clr mid-sweep returns everything to reset values next cycle; no write is issued.
  - clr has priority over abort, start and cfg_wr.
- busy=1 in LOAD, DWELL and STEP.

Decomposition:
- Package gen_sweep_pkg holds:
  - the state enum;
  - config address constants ADDR_START..ADDR_MODE;
  - MODE bit indices CONT_BIT and TRI_BIT.
- Sub-module sweep_next (purely combinational). Inputs: cur, STEP, lo, hi, dir, mode. Outputs: next value, next dir, end flag. This keeps the clamp and turn-around arithmetic unit-testable.
- The FSM and dwell counter stay in the top module.

Test Plan:
1. Single up sweep:
   - Stimulus: START=10, STOP=40, STEP=10, DWELL=3, MODE=0; start.
   - Response: writes 10,20,30,40 spaced 4 cycles apart; done pulses 4 cycles after the write of 40; busy low afterwards.
2. Clamp and down:
   - Stimulus: START=250, STOP=5, STEP=100, DWELL=1.
   - Response: writes 250,150,50,5; no wrap below 0; done asserted.
3. Triangle continuous:
   - Stimulus: START=0, STOP=8, STEP=4, DWELL=1, MODE=3.
   - Response: write sequence 0,4,8,4,0,4,8... with no done.
   - Then abort: wr_n stays 1 from the next cycle, busy=0, done never pulses.
4. Degenerate cases:
   - STEP=0: exactly one write (START), then done.
   - DWELL=0: writes spaced 2 cycles apart, identical to DWELL=1.
5. Mid-sweep config:
   - Stimulus: during a sweep, write STOP=200.
   - Response: the current sweep still ends at the old STOP; the next start uses 200.
   - Also: start pulse while busy changes nothing.
6. Reset mid-operation:
   - Stimulus: assert clr during DWELL.
   - Response: next cycle wr_n=1, cur_inc=0, busy=0, config registers at reset values; a subsequent start gives a single write of 0 (START=STOP=0 ends immediately) and then done.
